mem_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-port 1 KiB byte-addressed data/instruction memory between the instruction-fetch stage and the load/store stage. It grants one requester at a time, issues stores as sequential single-byte writes, returns loads with byte/half extraction and sign/zero extension, and flags misaligned accesses. It sits between the core's fetch/memory stages and the memory block.

---
 rtl/mem_arbiter_pkg.sv | 44 ++++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter_load_extend.sv | 21 ++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: access sizes, sequencer
// states, grant identifiers and small decode helpers.
package mem_pkg;

  localparam int ADDR_W = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_RESP  = 2'd1,
    WR_BYTE  = 2'd2,
    ERR_RESP = 2'd3
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_e;

  // Size code 2'b11 behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic res;
    case (size)
      SZ_BYTE: res = 1'b0;
      SZ_HALF: res = addr_lsb[0];
      default: res = (addr_lsb != 2'b00);
    endcase
    return res;
  endfunction

  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    logic [1:0] res;
    case (size)
      SZ_BYTE: res = 2'd0;
      SZ_HALF: res = 2'd1;
      default: res = 2'd3;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals around the arbiter.
// Handshake: a requester holds req (with its address/controls) until ready is
// seen high in a cycle; that cycle is the accept. rvalid is a one-cycle pulse.
interface mem_arbiter_if;
  logic        i_req;
  logic [9:0]  i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        mem_wen;
  logic        mem_b;
  logic        mem_h;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_dout,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata, d_err,
           mem_wen, mem_b, mem_h, mem_addr, mem_din
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_dout,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata, d_err,
           mem_wen, mem_b, mem_h, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_arbiter_load_extend.sv
// Load data formatting: picks the low byte/half of the memory word and
// sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] dout_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = dout_i;
    case (size_i)
      SZ_BYTE: result_o = {{24{dout_i[7] & ~unsigned_i}}, dout_i[7:0]};
      SZ_HALF: result_o = {{16{dout_i[15] & ~unsigned_i}}, dout_i[15:0]};
      default: result_o = dout_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-addressed memory between instruction fetch and load/store:
// round-robin grant, byte-serial stores, extended loads, misalignment errors.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output state_e        dbg_state_o
);

  state_e      state_q;
  grant_e      last_grant_q;
  logic [1:0]  k_q;
  logic [1:0]  last_k_q;
  logic [1:0]  k_inc;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [9:0]  addr_q;
  logic [31:0] wdata_q;

  logic        i_rvalid_q;
  logic        d_rvalid_q;
  logic        d_err_q;
  logic        i_pend_q;
  logic        d_pend_q;
  logic        mem_wen_q;
  logic        mem_b_q;
  logic [9:0]  mem_addr_q;
  logic [31:0] mem_din_q;

  logic        gnt_i;
  logic        gnt_d;
  logic [9:0]  idle_addr;
  logic [31:0] ext_data;

  // Grant decision: only in IDLE; on a tie the port not served last wins.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.i_req && bus.d_req) begin
        if (last_grant_q == FETCH) gnt_d = 1'b1;
        else                       gnt_i = 1'b1;
      end else begin
        gnt_i = bus.i_req;
        gnt_d = bus.d_req;
      end
    end
  end

  always_comb begin
    idle_addr = '0;
    if (gnt_d)      idle_addr = bus.d_addr;
    else if (gnt_i) idle_addr = bus.i_addr;
  end

  assign k_inc = k_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= FETCH;
      k_q          <= 2'd0;
      last_k_q     <= 2'd0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_err_q      <= 1'b0;
      i_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_b_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      i_pend_q   <= 1'b0;
      d_pend_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_wen_q <= 1'b0;
          mem_b_q   <= 1'b0;
          mem_din_q <= '0;
          if (gnt_d) begin
            last_grant_q <= DATA;
            size_q       <= bus.d_size;
            uns_q        <= bus.d_unsigned;
            addr_q       <= bus.d_addr;
            wdata_q      <= bus.d_wdata;
            last_k_q     <= last_byte_idx(bus.d_size);
            if (misaligned(bus.d_size, bus.d_addr[1:0])) begin
              state_q    <= ERR_RESP;
              d_rvalid_q <= 1'b1;
              d_err_q    <= 1'b1;
            end else if (bus.d_we) begin
              // First byte goes out in the cycle after accept.
              state_q    <= WR_BYTE;
              k_q        <= 2'd0;
              mem_wen_q  <= 1'b1;
              mem_b_q    <= 1'b1;
              mem_addr_q <= bus.d_addr;
              mem_din_q  <= {24'd0, bus.d_wdata[7:0]};
              d_rvalid_q <= (last_byte_idx(bus.d_size) == 2'd0);
            end else begin
              state_q    <= RD_RESP;
              d_rvalid_q <= 1'b1;
              d_pend_q   <= 1'b1;
            end
          end else if (gnt_i) begin
            last_grant_q <= FETCH;
            i_rvalid_q   <= 1'b1;
            if (bus.i_addr[1:0] != 2'b00) begin
              state_q <= ERR_RESP;
            end else begin
              state_q  <= RD_RESP;
              i_pend_q <= 1'b1;
            end
          end
        end
        RD_RESP, ERR_RESP: begin
          state_q <= IDLE;
        end
        WR_BYTE: begin
          if (k_q == last_k_q) begin
            state_q   <= IDLE;
            k_q       <= 2'd0;
            mem_wen_q <= 1'b0;
            mem_b_q   <= 1'b0;
            mem_din_q <= '0;
          end else begin
            k_q        <= k_inc;
            mem_addr_q <= addr_q + {8'd0, k_inc};
            mem_din_q  <= {24'd0, wdata_q[{k_inc, 3'b000} +: 8]};
            d_rvalid_q <= (k_inc == last_k_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  load_extend u_load_extend (
    .dout_i     (bus.mem_dout),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (ext_data)
  );

  // Read data comes straight off the memory's output register, gated by a
  // registered flag so it is only nonzero in the response cycle.
  assign bus.i_rdata  = i_pend_q ? bus.mem_dout : '0;
  assign bus.d_rdata  = d_pend_q ? ext_data : '0;
  assign bus.i_ready  = gnt_i;
  assign bus.d_ready  = gnt_d;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_err    = d_err_q;
  assign bus.mem_wen  = mem_wen_q;
  assign bus.mem_b    = mem_b_q;
  assign bus.mem_h    = 1'b0;
  assign bus.mem_din  = mem_din_q;
  assign bus.mem_addr = (state_q == IDLE) ? idle_addr : mem_addr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory model, write scoreboard and a
// transaction-level reference of memory contents and load results.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks;
  int n_fail;
  logic mon_en;
  logic mem_load;
  logic [7:0]  mem     [1024];
  logic [7:0]  ref_mem [1024];
  logic [17:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory block: byte writes, registered word read {a+3..a}.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int a = 0; a < 1024; a++) mem[a] <= ref_mem[a];
    end else if (bus.mem_wen === 1'b1) begin
      mem[bus.mem_addr] <= bus.mem_din[7:0];
    end
    bus.mem_dout <= {mem[bus.mem_addr + 10'd3], mem[bus.mem_addr + 10'd2],
                     mem[bus.mem_addr + 10'd1], mem[bus.mem_addr]};
  end

  // Write scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (bus.mem_h !== 1'b0 || (bus.mem_wen === 1'b1 && bus.mem_b !== 1'b1)) begin
        n_fail++;
        $display("FAIL mem_ctrl: mem_h=%b mem_b=%b mem_wen=%b", bus.mem_h, bus.mem_b, bus.mem_wen);
      end
      if (bus.mem_wen === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%h din=%h, none expected", bus.mem_addr, bus.mem_din);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if ({bus.mem_addr, bus.mem_din} !== {e[17:8], 24'd0, e[7:0]}) begin
            n_fail++;
            $display("FAIL write: got addr=%h din=%h, expected addr=%h din=%h",
                     bus.mem_addr, bus.mem_din, e[17:8], {24'd0, e[7:0]});
          end
        end
      end
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [9:0] a);
    return (sz == SZ_HALF && (a % 2) != 0) || (nbytes(sz) == 4 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [9:0] a);
    int unsigned v;
    int nb;
    nb = nbytes(sz);
    v = 0;
    for (int k = 0; k < nb; k++) v = v + (int'(ref_mem[(int'(a) + k) % 1024]) << (8 * k));
    if (!uns && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drivers start and end at posedge+1.
  task automatic data_txn(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat, output logic ok);
    int n = 0;
    bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns; bus.d_addr = a; bus.d_wdata = wd;
    bus.d_req = 1'b1;
    #1;
    while (!bus.d_ready && n < 20) begin @(posedge clk); #2; n++; end
    ok = bus.d_ready; lat = 0; rd = 'x; err = 'x;
    @(posedge clk); #1 bus.d_req = 1'b0;
    #1 lat = 1;
    while (ok && !bus.d_rvalid && lat < 10) begin @(posedge clk); #2; lat++; end
    ok = ok && bus.d_rvalid; rd = bus.d_rdata; err = bus.d_err;
    @(posedge clk); #1;
  endtask

  task automatic fetch_txn(input logic [9:0] a, output logic [31:0] rd, output int lat, output logic ok);
    int n = 0;
    bus.i_addr = a; bus.i_req = 1'b1;
    #1;
    while (!bus.i_ready && n < 20) begin @(posedge clk); #2; n++; end
    ok = bus.i_ready; lat = 0; rd = 'x;
    @(posedge clk); #1 bus.i_req = 1'b0;
    #1 lat = 1;
    while (ok && !bus.i_rvalid && lat < 10) begin @(posedge clk); #2; lat++; end
    ok = ok && bus.i_rvalid; rd = bus.i_rdata;
    @(posedge clk); #1;
  endtask

  // Store through the model: queue expected writes and update reference memory.
  task automatic model_store(input logic [1:0] sz, input logic [9:0] a, input logic [31:0] wd);
    for (int k = 0; k < nbytes(sz); k++) begin
      logic [9:0] wa;
      wa = 10'((int'(a) + k) % 1024);
      exp_q.push_back({wa, 8'((wd >> (8 * k)) & 32'hFF)});
      ref_mem[wa] = 8'((wd >> (8 * k)) & 32'hFF);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid, bus.d_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_hs: got %b expected 00000",
        {bus.i_ready, bus.d_ready, bus.i_rvalid, bus.d_rvalid, bus.d_err});
    end
    n_checks++;
    if (bus.i_rdata !== 32'd0 || bus.d_rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.i_rdata, bus.d_rdata);
    end
    n_checks++;
    if ({bus.mem_wen, bus.mem_b, bus.mem_h, bus.mem_addr, bus.mem_din} !== 45'd0) begin
      n_fail++; $display("FAIL reset_mem: wen=%b b=%b h=%b addr=%h din=%h expected all 0",
        bus.mem_wen, bus.mem_b, bus.mem_h, bus.mem_addr, bus.mem_din);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] rd; int lat; logic ok;
    fetch_txn(10'h010, rd, lat, ok);
    n_checks++;
    if (!ok || lat != 1 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL fetch: ok=%b lat=%0d rdata=%h expected ok=1 lat=1 rdata=deadbeef", ok, lat, rd);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic err; int lat; logic ok;
    model_store(SZ_WORD, 10'h020, 32'h11223344);
    data_txn(1'b1, SZ_WORD, 1'b0, 10'h020, 32'h11223344, rd, err, lat, ok);
    n_checks++;
    if (!ok || lat != 4 || err !== 1'b0 || rd !== 32'd0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL store_word: ok=%b lat=%0d err=%b rdata=%h left=%0d expected 1/4/0/0/0",
        ok, lat, err, rd, exp_q.size());
    end
    data_txn(1'b0, SZ_BYTE, 1'b0, 10'h023, 32'd0, rd, err, lat, ok);
    n_checks++;
    if (!ok || lat != 1 || err !== 1'b0 || rd !== 32'h00000011) begin
      n_fail++; $display("FAIL load_byte_s: ok=%b lat=%0d err=%b rdata=%h expected 1/1/0/00000011", ok, lat, err, rd);
    end
    model_store(SZ_HALF, 10'h020, 32'h00008001);
    data_txn(1'b1, SZ_HALF, 1'b0, 10'h020, 32'h00008001, rd, err, lat, ok);
    n_checks++;
    if (!ok || lat != 2 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL store_half: ok=%b lat=%0d left=%0d expected 1/2/0", ok, lat, exp_q.size());
    end
    data_txn(1'b0, SZ_HALF, 1'b0, 10'h020, 32'd0, rd, err, lat, ok);
    n_checks++;
    if (!ok || rd !== 32'hFFFF8001) begin
      n_fail++; $display("FAIL load_half_s: ok=%b rdata=%h expected ffff8001", ok, rd);
    end
    data_txn(1'b0, SZ_HALF, 1'b1, 10'h020, 32'd0, rd, err, lat, ok);
    n_checks++;
    if (!ok || rd !== 32'h00008001) begin
      n_fail++; $display("FAIL load_half_u: ok=%b rdata=%h expected 00008001", ok, rd);
    end
  endtask

  task automatic test_alternate();
    grant_e exp_g, got_g;
    int grants = 0;
    int resp_i = 0;
    int resp_d = 0;
    int cyc = 0;
    logic [31:0] exp_i, exp_d;
    apply_reset();
    exp_i = ref_load(SZ_WORD, 1'b1, 10'h040);
    exp_d = ref_load(SZ_HALF, 1'b0, 10'h082);
    bus.i_addr = 10'h040; bus.d_addr = 10'h082; bus.d_we = 1'b0;
    bus.d_size = SZ_HALF; bus.d_unsigned = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    #1;
    while ((grants < 6 || resp_i + resp_d < 6) && cyc < 60) begin
      if (bus.i_rvalid) begin
        resp_i++; n_checks++;
        if (bus.i_rdata !== exp_i) begin
          n_fail++; $display("FAIL alt_fetch_data: got %h expected %h", bus.i_rdata, exp_i);
        end
      end
      if (bus.d_rvalid) begin
        resp_d++; n_checks++;
        if (bus.d_rdata !== exp_d) begin
          n_fail++; $display("FAIL alt_data_data: got %h expected %h", bus.d_rdata, exp_d);
        end
      end
      if (bus.i_ready || bus.d_ready) begin
        exp_g = (grants % 2 == 0) ? DATA : FETCH;
        got_g = bus.d_ready ? DATA : FETCH;
        n_checks++;
        if (got_g !== exp_g || (bus.i_ready && bus.d_ready)) begin
          n_fail++; $display("FAIL alt_grant%0d: got %s (both=%b) expected %s",
            grants, got_g.name(), bus.i_ready && bus.d_ready, exp_g.name());
        end
        grants++;
      end
      @(posedge clk); #1;
      if (grants == 6) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      #1 cyc++;
    end
    n_checks++;
    if (grants != 6 || resp_i != 3 || resp_d != 3) begin
      n_fail++; $display("FAIL alt_count: grants=%0d fetch_resp=%0d data_resp=%0d expected 6/3/3", grants, resp_i, resp_d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err; int lat; logic ok;
    data_txn(1'b0, SZ_HALF, 1'b0, 10'h101, 32'd0, rd, err, lat, ok);
    n_checks++;
    if (!ok || lat != 1 || err !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL mis_half: ok=%b lat=%0d err=%b rdata=%h expected 1/1/1/0", ok, lat, err, rd);
    end
    data_txn(1'b1, SZ_WORD, 1'b0, 10'h0A2, 32'hCAFEF00D, rd, err, lat, ok);
    n_checks++;
    if (!ok || lat != 1 || err !== 1'b1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL mis_store: ok=%b lat=%0d err=%b rdata=%h expected 1/1/1/0", ok, lat, err, rd);
    end
    fetch_txn(10'h041, rd, lat, ok);
    n_checks++;
    if (!ok || lat != 1 || rd !== 32'd0) begin
      n_fail++; $display("FAIL mis_fetch: ok=%b lat=%0d rdata=%h expected 1/1/0", ok, lat, rd);
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    int seen = 0;
    bus.d_we = 1'b1; bus.d_size = SZ_WORD; bus.d_unsigned = 1'b0;
    bus.d_addr = 10'h200; bus.d_wdata = 32'h55667788; bus.d_req = 1'b1;
    exp_q.push_back({10'h200, 8'h88});
    #1;
    while (!bus.d_ready && n < 20) begin @(posedge clk); #2; n++; end
    n_checks++;
    if (!bus.d_ready) begin
      n_fail++; $display("FAIL abort_accept: d_ready=%b expected 1", bus.d_ready);
    end
    @(posedge clk); #1 bus.d_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== IDLE || {bus.mem_wen, bus.mem_b, bus.mem_addr, bus.mem_din} !== 44'd0 ||
        {bus.d_rvalid, bus.d_err} !== 2'b00 || bus.d_rdata !== 32'd0) begin
      n_fail++; $display("FAIL abort_outputs: state=%0d wen=%b b=%b addr=%h din=%h rvalid=%b err=%b rdata=%h expected all 0",
        dbg_state, bus.mem_wen, bus.mem_b, bus.mem_addr, bus.mem_din, bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    repeat (4) begin
      if (bus.d_rvalid) seen++;
      @(posedge clk); #2;
    end
    n_checks++;
    if (seen != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_tail: rvalids=%0d writes_missing=%0d expected 0/0", seen, exp_q.size());
    end
    ref_mem[10'h200] = 8'h88;
    #1;
  endtask

  task automatic test_top_byte();
    logic [31:0] rd; logic err; int lat; logic ok;
    model_store(SZ_BYTE, 10'h3FF, 32'h000000AB);
    data_txn(1'b1, SZ_BYTE, 1'b0, 10'h3FF, 32'h000000AB, rd, err, lat, ok);
    n_checks++;
    if (!ok || lat != 1 || err !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL top_store: ok=%b lat=%0d err=%b left=%0d expected 1/1/0/0", ok, lat, err, exp_q.size());
    end
    data_txn(1'b0, SZ_BYTE, 1'b1, 10'h3FF, 32'd0, rd, err, lat, ok);
    n_checks++;
    if (!ok || rd !== 32'h000000AB) begin
      n_fail++; $display("FAIL top_load: ok=%b rdata=%h expected 000000ab", ok, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat, exp_lat; logic ok;
    for (int it = 0; it < 60; it++) begin
      logic [9:0] a;
      logic [1:0] sz;
      logic we, uns;
      logic [31:0] wd;
      a = 10'($urandom_range(0, 1023));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        exp_rd = (a[1:0] != 2'b00) ? 32'd0 : ref_load(SZ_WORD, 1'b1, a);
        fetch_txn(a, rd, lat, ok);
        n_checks++;
        if (!ok || lat != 1 || rd !== exp_rd) begin
          n_fail++; $display("FAIL rnd_fetch%0d: addr=%h ok=%b lat=%0d rdata=%h expected lat=1 rdata=%h", it, a, ok, lat, rd, exp_rd);
        end
      end else begin
        if ($urandom_range(0, 3) != 0) a = a & ~10'(nbytes(sz) - 1);
        exp_err = is_mis(sz, a);
        exp_lat = (!exp_err && we) ? nbytes(sz) : 1;
        exp_rd = (exp_err || we) ? 32'd0 : ref_load(sz, uns, a);
        if (!exp_err && we) model_store(sz, a, wd);
        data_txn(we, sz, uns, a, wd, rd, err, lat, ok);
        n_checks++;
        if (!ok || lat != exp_lat || err !== exp_err || rd !== exp_rd || exp_q.size() != 0) begin
          n_fail++; $display("FAIL rnd_data%0d: we=%b sz=%0d addr=%h ok=%b lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
            it, we, sz, a, ok, lat, err, rd, exp_lat, exp_err, exp_rd);
        end
      end
    end
  endtask

  initial begin
    int diffs;
    n_checks = 0; n_fail = 0; mon_en = 1'b0; mem_load = 1'b1;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SZ_BYTE; bus.d_unsigned = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    for (int a = 0; a < 1024; a++) ref_mem[a] = 8'($urandom);
    ref_mem[16'h010] = 8'hEF; ref_mem[16'h011] = 8'hBE;
    ref_mem[16'h012] = 8'hAD; ref_mem[16'h013] = 8'hDE;
    @(posedge clk); #1 mem_load = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_fetch();
    test_store_load();
    test_alternate();
    test_misaligned();
    test_reset_abort();
    test_top_byte();
    test_random();
    diffs = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== ref_mem[a]) diffs++;
    n_checks++;
    if (diffs != 0) begin
      n_fail++; $display("FAIL mem_image: %0d bytes differ, expected 0", diffs);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
